gray_code_engine: RTL
=====================

Name: gray_code_engine

Overview:
Parametrised successor to the 4-bit binary-to-Gray converter. It combines a registered bidirectional converter with a Gray-code counter. The converter handles binary→Gray or Gray→binary per transaction, behind a valid/ready handshake. The counter is an up/down counter with load, producing binary and Gray values in lockstep. It serves as the shared Gray utility for CDC pointers, encoder interfaces and test stimulus.

Parameters:
WIDTH, 4, bit width of all data, counter and load values (legal range 2..32)
CNT_RESET, 0, binary reset value of the counter (must fit in WIDTH bits)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  conversion request valid
in_ready  out  1  converter can accept a request
in_g2b  in  1  0 = binary→Gray, 1 = Gray→binary; sampled with in_data
in_data  in  WIDTH  value to convert
out_valid  out  1  conversion result valid
out_ready  in  1  downstream accepts the result
out_data  out  WIDTH  conversion result
cnt_en  in  1  advance the counter by one step
cnt_down  in  1  0 = count up, 1 = count down
cnt_load  in  1  load the counter from load_bin
load_bin  in  WIDTH  binary load value
cnt_bin  out  WIDTH  registered binary count
cnt_gray  out  WIDTH  registered Gray count, always equal to bin2gray(cnt_bin)
cnt_wrap  out  1  one-cycle pulse on wrap-around

Behaviour:
- One clock, clk. Reset rst is synchronous, active-high, and overrides everything on the same edge.
- Reset values:
  - out_valid = 0, out_data = 0
  - cnt_bin = CNT_RESET, cnt_gray = bin2gray(CNT_RESET)
  - cnt_wrap = 0
  - in_ready = 1 in the cycle after reset.
- Conversion arithmetic:
  - bin2gray: G[i] = B[i] ^ B[i+1]; G[MSB] = B[MSB].
  - gray2bin: B[MSB] = G[MSB]; B[i] = B[i+1] ^ G[i] (prefix XOR, MSB down).
  - Both are pure functions of WIDTH bits; no truncation or extension.
- Converter handshake (single output register, latency 1):
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready. On the next edge, out_data = converted value and out_valid = 1.
  - Output transfer occurs when out_valid && out_ready. If no new accept happens on that edge, out_valid → 0.
  - Simultaneous accept and output transfer: out_data is replaced and out_valid stays 1. This gives full throughput of one conversion per cycle.
  - While out_valid && !out_ready, out_data and out_valid hold stable and in_ready = 0. Input is not sampled.
  - out_data changes only on an accept edge.
- Counter:
  - Priority per edge: rst > cnt_load > cnt_en.
  - Load: cnt_bin = load_bin, cnt_gray = bin2gray(load_bin), cnt_wrap = 0.
  - Enable, up: cnt_bin + 1 modulo 2^WIDTH. Enable, down: cnt_bin - 1 modulo 2^WIDTH.
  - cnt_gray is registered from bin2gray of the next binary value. Exactly one bit of cnt_gray changes per enabled step.
  - cnt_wrap = 1 for one cycle after an up-step from all-ones to 0, or a down-step from 0 to all-ones. Otherwise it is 0.
  - Idle (no load, no enable): both counts hold and cnt_wrap = 0.
  - The counter is fully independent of the converter path.
- Reset mid-transaction: a pending out_valid is dropped without transfer, and the counter returns to CNT_RESET. No partial state survives.

Decomposition:
- Shared package gray_pkg:
  - functions bin2gray(WIDTH) and gray2bin(WIDTH)
  - constant GRAY_MAX_WIDTH = 32
  - localparam for the direction encoding (G2B = 1'b1)
- One sub-module, gray_conv: a combinational converter (inputs data and g2b, output result). It is instantiated once for the handshake path. The counter uses the bin2gray package function directly.

Test Plan:
- WIDTH=4, out_ready=1: send in_data=4'b1011, in_g2b=0 → next cycle out_valid=1, out_data=4'b1110. Send 4'b1110, in_g2b=1 → out_data=4'b1011.
- Back-to-back accepts on consecutive cycles with 0..15 in both modes → 16 results in order, each a cycle apart. gray2bin(bin2gray(x)) == x for all x.
- Backpressure: accept 4'b0101, hold out_ready=0 for 3 cycles → out_data=4'b0111 stable, in_ready=0, new in_data ignored. Raise out_ready together with in_valid → the held result transfers and the new result appears next cycle.
- Counter up from reset with cnt_en=1 → cnt_gray 0000, 0001, 0011, 0010, 0110, …, 1000 at count 15, then 0000 with cnt_wrap=1 for one cycle. Assert single-bit Hamming distance on every step.
- cnt_load=1, load_bin=5 with cnt_en=1 on the same cycle → cnt_bin=5, cnt_gray=4'b0111, no increment that edge. Then down-count to 0 and one more step → cnt_bin=15, cnt_wrap=1.
- Assert rst while out_valid=1, out_ready=0 and counter at 9 → next cycle out_valid=0, out_data=0, cnt_bin=CNT_RESET, cnt_wrap=0, in_ready=1.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: width-agnostic conversions on a max-width word,
// plus the direction encoding and counter command bundle.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  localparam logic G2B = 1'b1;
  localparam logic B2G = 1'b0;

  typedef logic [GRAY_MAX_WIDTH-1:0] gword_t;

  typedef struct packed {
    logic load;
    logic en;
    logic down;
  } cnt_cmd_t;

  // Zero upper bits stay zero, so callers may truncate to any WIDTH.
  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational bidirectional converter: binary->Gray or Gray->binary per g2b_i.
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             g2b_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] to_gray;
  logic [WIDTH-1:0] to_bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == WIDTH - 1) begin : g_msb
      assign to_gray[i] = data_i[i];
    end else begin : g_lsb
      assign to_gray[i] = data_i[i] ^ data_i[i+1];
    end
    // Binary bit i is the XOR of every Gray bit at or above it.
    assign to_bin[i] = ^data_i[WIDTH-1:i];
  end

  assign result_o = (g2b_i == G2B) ? to_bin : to_gray;

endmodule

// File: rtl/gray_code_engine.sv
// Registered Gray converter behind a valid/ready handshake, plus an
// independent up/down/load Gray counter with a wrap pulse.
module gray_code_engine
  import gray_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned CNT_RESET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_g2b,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_en,
  input  logic             cnt_down,
  input  logic             cnt_load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             cnt_wrap
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(CNT_RESET);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RST_BIN)));

  // ---------------- converter path ----------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] conv_res;
  logic             accept;

  gray_conv #(.WIDTH(WIDTH)) u_conv (
    .data_i   (in_data),
    .g2b_i    (in_g2b),
    .result_o (conv_res)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d  = accept ? conv_res : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // ---------------- counter ----------------
  cnt_cmd_t         cmd;
  logic [WIDTH-1:0] cnt_bin_q, cnt_bin_d;
  logic [WIDTH-1:0] cnt_gray_q, cnt_gray_d;
  logic             cnt_wrap_q, cnt_wrap_d;

  assign cmd = '{load: cnt_load, en: cnt_en, down: cnt_down};

  always_comb begin
    cnt_bin_d  = cnt_bin_q;
    cnt_wrap_d = 1'b0;
    if (cmd.load) begin
      cnt_bin_d = load_bin;
    end else if (cmd.en) begin
      if (cmd.down) begin
        cnt_bin_d  = cnt_bin_q - 1'b1;
        cnt_wrap_d = (cnt_bin_q == '0);
      end else begin
        cnt_bin_d  = cnt_bin_q + 1'b1;
        cnt_wrap_d = (cnt_bin_q == '1);
      end
    end
    // Gray is registered from the next binary value so both stay in lockstep.
    cnt_gray_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(cnt_bin_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_bin_q  <= RST_BIN;
      cnt_gray_q <= RST_GRAY;
      cnt_wrap_q <= 1'b0;
    end else begin
      cnt_bin_q  <= cnt_bin_d;
      cnt_gray_q <= cnt_gray_d;
      cnt_wrap_q <= cnt_wrap_d;
    end
  end

  assign cnt_bin  = cnt_bin_q;
  assign cnt_gray = cnt_gray_q;
  assign cnt_wrap = cnt_wrap_q;

endmodule
